fetch_queue: RTL

//  Instruction fetch stage feeding decode_top.

---
 rtl/fetch_queue.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests to imem and
// buffers responses in a DEPTH-entry FIFO for decode. Optional macro: FETCH_BYPASS_EN.
module fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    input  logic [1:0]            PCSrc,
    input  logic [DATA_WIDTH-1:0] ImmExt,
    input  logic [DATA_WIDTH-1:0] ALUResult
);
    localparam int                    AW      = $clog2(DEPTH);
    localparam int                    CW      = AW + 1;
    localparam logic [CW:0]           DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] STEP    = DATA_WIDTH'(4);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d, outst_q, outst_d, discard_q, discard_d;
    logic [DATA_WIDTH-1:0] word_mem [DEPTH];
    logic [DATA_WIDTH-1:0] addr_mem [DEPTH];

    logic                  head_valid, resp_ok, bypass, pop, fifo_pop, push;
    logic                  redirect, credit_ok;
    logic [DATA_WIDTH-1:0] target_raw, target;

    assign head_valid = (count_q != '0);
    // A response with nothing in flight is stray (e.g. issued before a reset) and is ignored.
    assign resp_ok    = imem_rvalid && (outst_q != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = (state_q == RUN) && !head_valid && resp_ok;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid = head_valid || bypass;

    always_comb begin
        instr = NOP;
        pc    = RESET_PC;
        if (head_valid) begin
            instr = word_mem[rd_ptr_q];
            pc    = addr_mem[rd_ptr_q];
        end else if (bypass) begin
            instr = imem_rdata;
            pc    = resp_pc_q;
        end
    end

    assign pc_plus4   = pc + STEP;
    assign pop        = instr_valid && instr_ready;
    assign fifo_pop   = head_valid && instr_ready;
    assign redirect   = pop && ((PCSrc == 2'b01) || (PCSrc == 2'b10));
    assign target_raw = (PCSrc == 2'b01) ? (pc + ImmExt) : ALUResult;
    assign target     = {target_raw[DATA_WIDTH-1:2], 2'b00};

    assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C;
    assign imem_req  = (state_q == RUN) && credit_ok && !redirect;
    assign imem_addr = fetch_pc_q;
    assign push      = (state_q == RUN) && resp_ok && !redirect && !(bypass && instr_ready);

    // resp_pc_q tracks the address of the oldest in-flight request, so pushed entries get exact PCs.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q + CW'(push) - CW'(fifo_pop);
        outst_d    = outst_q + CW'(imem_req) - CW'(resp_ok);
        discard_d  = discard_q;

        if (imem_req)
            fetch_pc_d = fetch_pc_q + STEP;
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (fifo_pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if ((state_q == RUN) && resp_ok)
            resp_pc_d = resp_pc_q + STEP;

        if (redirect) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outst_d;
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redirect && (discard_d != '0)) state_d = FLUSH;
            FLUSH: begin
                if (resp_ok)
                    discard_d = discard_q - CW'(1);
                if (discard_d == '0)
                    state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= imem_rdata;
            addr_mem[wr_ptr_q] <= resp_pc_q;
        end
    end

endmodule
